sample_feeder: RTL and testbench

- Upstream stage of the neuron training datapath.
- Buffers a training set of (X1, X2, t) samples written by the host or testbench.
- On start, streams the set to the neuron module one sample per accepted handshake, repeating whole epochs until the neuron reports a clean epoch or an epoch limit is reached.
- Drives the neuron's X1Bus/X2Bus/tBus, nBus and start inputs.

---
 rtl/sample_feeder_pkg.sv | 21 ++
 rtl/sample_feeder_mem.sv | 33 +++
 rtl/sample_feeder.sv | 251 +++++++++++++++++++++++++
 tb/tb_sample_feeder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_feeder_pkg.sv
// Shared definitions for the sample feeder: default widths, the packed
// sample width and the run-control state encoding.
package sample_feeder_pkg;

  localparam int DEPTH_DEF = 512;  // sample capacity (power of two)
  localparam int XW_DEF    = 7;    // signed width of X1/X2
  localparam int TW_DEF    = 2;    // signed width of target t
  localparam int EPW_DEF   = 8;    // epoch counter / limit width

  // One stored sample is {x1, x2, t}, kept verbatim.
  localparam int SW = 2 * XW_DEF + TW_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_STREAM,
    ST_EPOCH_END,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sample_feeder_mem.sv
// Training-set storage: DEPTH x W register array, one synchronous write
// port and one asynchronous (combinational) read port. Contents are not
// reset.
//   clk      in  clock
//   we_i     in  write enable
//   waddr_i  in  write address
//   wdata_i  in  write data
//   raddr_i  in  read address
//   rdata_o  out read data (combinational from raddr_i)
module sample_mem #(
  parameter int DEPTH = 512,
  parameter int W     = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sample_feeder.sv
// Upstream stage of the neuron training datapath. Buffers a training set of
// (X1, X2, t) samples while idle, then streams the set to the neuron one
// sample per valid/ready handshake, repeating whole epochs until the neuron
// reports a clean epoch or the epoch limit is reached.
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/wr_x1/x2/t    sample write (IDLE only)
//   clear               empty the buffer (IDLE only)
//   start / abort       begin / cancel a training run
//   epochs_max          epoch limit (0 behaves as 1)
//   ready, epoch_clean  handshake and epoch status from the neuron
//   x1_bus/x2_bus/t_bus sample presented to the neuron
//   valid, last         bus qualifier and end-of-epoch marker
//   n_bus, nrn_start    sample count and run start pulse to the neuron
//   epoch_cnt, count    completed epochs, samples stored
//   ovf, busy, done     sticky overflow, run in progress, run-end pulse
module sample_feeder
  import sample_feeder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int XW    = XW_DEF,
  parameter int TW    = TW_DEF,
  parameter int EPW   = EPW_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic signed [XW-1:0]       wr_x1,
  input  logic signed [XW-1:0]       wr_x2,
  input  logic signed [TW-1:0]       wr_t,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       abort,
  input  logic [EPW-1:0]             epochs_max,
  input  logic                       ready,
  input  logic                       epoch_clean,
  output logic signed [XW-1:0]       x1_bus,
  output logic signed [XW-1:0]       x2_bus,
  output logic signed [TW-1:0]       t_bus,
  output logic                       valid,
  output logic                       last,
  output logic [31:0]                n_bus,
  output logic                       nrn_start,
  output logic [EPW-1:0]             epoch_cnt,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  output logic                       busy,
  output logic                       done
);

  localparam int SMP_W = 2 * XW + TW;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  // Epoch counter increments but never wraps.
  function automatic logic [EPW-1:0] sat_inc(input logic [EPW-1:0] v);
    return (&v) ? v : v + EPW'(1);
  endfunction

  state_e                 state_q, state_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic signed [XW-1:0]   x1_q, x1_d;
  logic signed [XW-1:0]   x2_q, x2_d;
  logic signed [TW-1:0]   t_q, t_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic [31:0]            nbus_q, nbus_d;
  logic [EPW-1:0]         epoch_q, epoch_d;

  logic                   mem_we;
  logic [AW-1:0]          wr_addr;
  logic [SMP_W-1:0]       wr_data;
  logic [AW-1:0]          rd_addr;
  logic [SMP_W-1:0]       rd_data;
  logic signed [XW-1:0]   rd_x1;
  logic signed [XW-1:0]   rd_x2;
  logic signed [TW-1:0]   rd_t;
  logic [EPW-1:0]         epoch_inc;
  logic [EPW-1:0]         epoch_lim;
  logic                   buf_full;
  logic                   one_sample;

  assign wr_addr = count_q[AW-1:0];
  assign wr_data = {wr_x1, wr_x2, wr_t};

  // While streaming, the read port looks one sample ahead so the output
  // registers can reload on the same edge as a transfer. Every other load
  // (ARM, epoch restart) fetches sample 0.
  assign rd_addr = (state_q == ST_STREAM) ? rd_ptr_q + AW'(1) : '0;

  sample_mem #(
    .DEPTH (DEPTH),
    .W     (SMP_W),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign rd_x1 = rd_data[SMP_W-1 -: XW];
  assign rd_x2 = rd_data[TW +: XW];
  assign rd_t  = rd_data[TW-1:0];

  assign buf_full   = (count_q == CW'(DEPTH));
  assign one_sample = (count_q == CW'(1));
  assign epoch_inc  = sat_inc(epoch_q);
  assign epoch_lim  = (epochs_max == '0) ? EPW'(1) : epochs_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      x1_q     <= '0;
      x2_q     <= '0;
      t_q      <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      nbus_q   <= '0;
      epoch_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      t_q      <= t_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      nbus_q   <= nbus_d;
      epoch_q  <= epoch_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    t_d      = t_q;
    valid_d  = valid_q;
    last_d   = last_q;
    nbus_d   = nbus_q;
    epoch_d  = epoch_q;
    mem_we   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A start that launches a run takes precedence over clear and
        // write in the same cycle, so n_bus always matches the buffer.
        if (start && (count_q != '0)) begin
          nbus_d   = 32'(count_q);
          epoch_d  = '0;
          rd_ptr_d = '0;
          state_d  = ST_ARM;
        end else if (clear) begin
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (wr_en) begin
          if (buf_full) begin
            ovf_d = 1'b1;
          end else begin
            mem_we  = 1'b1;
            count_d = count_q + CW'(1);
          end
        end
      end

      ST_ARM: begin
        x1_d    = rd_x1;
        x2_d    = rd_x2;
        t_d     = rd_t;
        valid_d = 1'b1;
        last_d  = one_sample;
        state_d = ST_STREAM;
      end

      ST_STREAM: begin
        if (valid_q && ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = ST_EPOCH_END;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            x1_d     = rd_x1;
            x2_d     = rd_x2;
            t_d      = rd_t;
            // Next sample is final when rd_ptr+1 == count-1.
            last_d   = ((CW'(rd_ptr_q) + CW'(2)) == count_q);
          end
        end
      end

      ST_EPOCH_END: begin
        epoch_d = epoch_inc;
        if (epoch_clean || (epoch_inc >= epoch_lim)) begin
          state_d = ST_DONE;
        end else begin
          rd_ptr_d = '0;
          x1_d     = rd_x1;
          x2_d     = rd_x2;
          t_d      = rd_t;
          valid_d  = 1'b1;
          last_d   = one_sample;
          state_d  = ST_STREAM;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort cancels the run from any active state without a done pulse and
    // leaves the epoch count as it was.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
      epoch_d = epoch_q;
    end
  end

  assign x1_bus    = x1_q;
  assign x2_bus    = x2_q;
  assign t_bus     = t_q;
  assign valid     = valid_q;
  assign last      = last_q;
  assign n_bus     = nbus_q;
  assign epoch_cnt = epoch_q;
  assign count     = count_q;
  assign ovf       = ovf_q;
  assign nrn_start = (state_q == ST_ARM);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_sample_feeder.sv
module tb_sample_feeder;

  localparam int DEPTH = 512;
  localparam int XW    = 7;
  localparam int TW    = 2;
  localparam int EPW   = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_en = 1'b0;
  logic [XW-1:0]   wr_x1 = '0;
  logic [XW-1:0]   wr_x2 = '0;
  logic [TW-1:0]   wr_t = '0;
  logic            clear = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [EPW-1:0]  epochs_max = '0;
  logic            ready = 1'b0;
  logic            epoch_clean = 1'b0;
  logic [XW-1:0]   x1_bus;
  logic [XW-1:0]   x2_bus;
  logic [TW-1:0]   t_bus;
  logic            valid;
  logic            last;
  logic [31:0]     n_bus;
  logic            nrn_start;
  logic [EPW-1:0]  epoch_cnt;
  logic [CW-1:0]   count;
  logic            ovf;
  logic            busy;
  logic            done;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the buffer is just an ordered list of {x1,x2,t}.
  logic [15:0] q[$];
  logic        ovf_m = 1'b0;

  always #5 clk = ~clk;

  sample_feeder #(
    .DEPTH(DEPTH), .XW(XW), .TW(TW), .EPW(EPW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_x1(wr_x1), .wr_x2(wr_x2),
    .wr_t(wr_t), .clear(clear), .start(start), .abort(abort),
    .epochs_max(epochs_max), .ready(ready), .epoch_clean(epoch_clean),
    .x1_bus(x1_bus), .x2_bus(x2_bus), .t_bus(t_bus), .valid(valid),
    .last(last), .n_bus(n_bus), .nrn_start(nrn_start), .epoch_cnt(epoch_cnt),
    .count(count), .ovf(ovf), .busy(busy), .done(done)
  );

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_sample();
    logic [31:0] r;
    r = $urandom();
    return r[15:0];
  endfunction

  task automatic wr_sample(input logic [15:0] s);
    {wr_x1, wr_x2, wr_t} = s;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    if (q.size() < DEPTH) q.push_back(s);
    else ovf_m = 1'b1;
  endtask

  task automatic clear_buf();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    chk("clear_count", count, 0);
    chk("clear_ovf", ovf, 0);
  endtask

  // One training run: every visible bus value is compared against the
  // model's next-expected sample; epoch and transfer totals follow from
  // the stop rule (clean epoch or limit, limit 0 meaning 1).
  task automatic run(input int lim_f, input int clean_at, input int stall_pct,
                     input int stall_at, input bit with_clear);
    int cnt    = q.size();
    int lim    = (lim_f == 0) ? 1 : lim_f;
    int exp_ep = (clean_at >= 1 && clean_at < lim) ? clean_at : lim;
    int k = 0, ep = 0, xfers = 0, dones = 0, stalls = 0;
    bit finished = 1'b0;
    logic rdy;
    logic [15:0] s;
    epochs_max  = EPW'(lim_f);
    epoch_clean = 1'b0;
    ready       = 1'b0;
    start       = 1'b1;
    clear       = with_clear;
    tick();
    start = 1'b0;
    clear = 1'b0;
    chk("nrn_start_pulse", nrn_start, 1);
    chk("arm_valid_low", valid, 0);
    chk("n_bus", n_bus, cnt);
    chk("busy_run", busy, 1);
    chk("count_kept", count, cnt);
    tick();
    chk("nrn_start_single", nrn_start, 0);
    chk("first_valid", valid, 1);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (done) dones++;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      if (valid) begin
        s = q[k];
        chk("x1_bus", x1_bus, s[15:9]);
        chk("x2_bus", x2_bus, s[8:2]);
        chk("t_bus", t_bus, s[1:0]);
        chk("last", last, (k == cnt - 1));
      end
      rdy = ($urandom_range(99) >= stall_pct);
      if (ep == 0 && k == stall_at && stalls < 3 && valid) begin
        rdy = 1'b0;
        stalls++;
      end
      ready = rdy;
      if (valid && rdy) begin
        xfers++;
        k++;
        if (k == cnt) begin
          k = 0;
          ep++;
        end
      end
      epoch_clean = (ep == clean_at);
      tick();
    end
    chk("run_finished", finished, 1);
    chk("epoch_cnt", epoch_cnt, exp_ep);
    chk("transfers", xfers, exp_ep * cnt);
    chk("done_pulses", dones, 1);
    chk("n_bus_hold", n_bus, cnt);
    chk("done_low_after", done, 0);
    ready       = 1'b0;
    epoch_clean = 1'b0;
  endtask

  initial begin
    int n, lim, cl;
    // Reset state
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_outputs", {x1_bus, x2_bus, t_bus, last, n_bus, nrn_start, epoch_cnt, ovf, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Load 5 samples, first one (-16, -16, -1)
    wr_sample({7'b1110000, 7'b1110000, 2'b11});
    for (int i = 0; i < 4; i++) wr_sample(rand_sample());
    chk("load_count", count, 5);

    // Single epoch, 3-cycle stall on sample 2
    run(1, 0, 0, 2, 1'b0);
    // Three epochs, never clean; then clean at the 2nd epoch end
    run(3, 0, 30, -1, 1'b0);
    run(3, 2, 30, -1, 1'b1);

    // Randomised sets and epoch controls
    for (int it = 0; it < 4; it++) begin
      clear_buf();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) wr_sample(rand_sample());
      chk("rnd_count", count, q.size());
      lim = $urandom_range(1, 4);
      cl  = $urandom_range(0, lim);
      run(lim, cl, 40, -1, it[0]);
    end

    // Single-sample buffer with epochs_max=0
    clear_buf();
    wr_sample(rand_sample());
    run(0, 0, 20, -1, 1'b0);

    // Buffer frozen during a run, then abort in the second epoch
    clear_buf();
    for (int i = 0; i < 4; i++) wr_sample(rand_sample());
    epochs_max = 8'd3;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && !(epoch_cnt == 1 && valid); i++) tick();
    chk("abort_reached", (epoch_cnt == 1 && valid), 1);
    wr_en = 1'b1;
    clear = 1'b1;
    start = 1'b1;
    tick();
    wr_en = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    chk("frozen_count", count, 4);
    chk("frozen_busy", busy, 1);
    chk("frozen_nostart", nrn_start, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ready = 1'b0;
    chk("abort_valid", valid, 0);
    chk("abort_last", last, 0);
    chk("abort_busy", busy, 0);
    chk("abort_epoch_hold", epoch_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", done, 0);
      tick();
    end

    // Asynchronous reset in the middle of streaming
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_reset_valid", valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_outputs", {x1_bus, x2_bus, t_bus, last, n_bus, epoch_cnt}, 0);
    q.delete();
    ovf_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fill past capacity
    for (int i = 0; i < DEPTH; i++) wr_sample(rand_sample());
    chk("full_no_ovf_yet", ovf, 0);
    wr_sample(rand_sample());
    wr_sample(rand_sample());
    chk("full_count", count, DEPTH);
    chk("full_ovf", ovf, ovf_m);
    run(1, 0, 10, -1, 1'b0);

    // Clear wins over write; empty start is ignored
    clear = 1'b1;
    wr_en = 1'b1;
    tick();
    clear = 1'b0;
    wr_en = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    chk("clear_over_wr_count", count, 0);
    chk("clear_over_wr_ovf", ovf, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty_start_busy", busy, 0);
    chk("empty_start_pulse", nrn_start, 0);
    tick();
    chk("empty_start_valid", valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
